// File: rtl/bt_test_pkg.sv
// Shared types and message ROM for the Bluetooth link test source.
// Optional parity framing is selected by BT_TEST_PARITY_EN in the users of this package.
package bt_test_pkg;

  typedef enum logic [2:0] {GAP, START, DATA, PARITY, STOP} state_e;
  typedef enum logic {SEQ_GAP, SEQ_SEND} seq_e;

  localparam int unsigned MSG_LEN = 4;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned IDX_W   = $clog2(MSG_LEN);

  // "AT\r\n", byte 0 in the most significant position
  localparam logic [MSG_LEN*BYTE_W-1:0] MSG_ROM = {8'h41, 8'h54, 8'h0D, 8'h0A};

  function automatic logic [BYTE_W-1:0] msg_byte(input logic [IDX_W-1:0] idx);
    logic [BYTE_W-1:0] b;
    case (idx)
      2'd0:    b = MSG_ROM[31:24];
      2'd1:    b = MSG_ROM[23:16];
      2'd2:    b = MSG_ROM[15:8];
      default: b = MSG_ROM[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_tx_core.sv
// Byte serializer: start bit, 8 data bits LSB first, optional even parity, one stop bit.
// Define BT_TEST_PARITY_EN for 8E1 framing; default is 8N1.
module uart_tx_core
  import bt_test_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic              c_o,
  output logic              busy_o,
  output logic              done_o
);

  localparam int unsigned       CNT_W   = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              c_q, c_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
`ifdef BT_TEST_PARITY_EN
  logic              par_q, par_d;
`endif

  logic bit_tick_c;
  logic load_c;

  assign bit_tick_c = (cnt_q == CNT_MAX);
  // A new byte may start from idle or exactly at the end of a stop bit
  assign load_c = start_i && ((state_q == GAP) || ((state_q == STOP) && bit_tick_c));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= GAP;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      c_q       <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef BT_TEST_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      c_q       <= c_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef BT_TEST_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = bit_tick_c ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    c_d       = c_q;
`ifdef BT_TEST_PARITY_EN
    par_d     = par_q;
`endif

    case (state_q)
      GAP: begin
        cnt_d = '0;
        c_d   = 1'b1;
      end
      START: begin
        if (bit_tick_c) begin
          state_d   = DATA;
          bit_idx_d = '0;
          c_d       = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
      DATA: begin
        if (bit_tick_c) begin
          if (bit_idx_q == 3'd7) begin
`ifdef BT_TEST_PARITY_EN
            state_d = PARITY;
            c_d     = par_q;
`else
            state_d = STOP;
            c_d     = 1'b1;
`endif
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            c_d       = shift_q[0];
            shift_d   = shift_q >> 1;
          end
        end
      end
`ifdef BT_TEST_PARITY_EN
      PARITY: begin
        if (bit_tick_c) begin
          state_d = STOP;
          c_d     = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_tick_c) begin
          state_d = GAP;
          c_d     = 1'b1;
        end
      end
      default: begin
        state_d = GAP;
        cnt_d   = '0;
        c_d     = 1'b1;
      end
    endcase

    if (load_c) begin
      state_d = START;
      cnt_d   = '0;
      c_d     = 1'b0;
      shift_d = data_i;
`ifdef BT_TEST_PARITY_EN
      par_d   = ^data_i;
`endif
    end

    // done marks the final cycle of the stop bit so the next byte can follow without idle
    done_d = (state_d == STOP) && (cnt_d == CNT_MAX);
    busy_d = (state_d != GAP);
  end

  assign c_o    = c_q;
  assign busy_o = busy_q;
  assign done_o = done_q;

endmodule

// File: rtl/bt_test_tx.sv
// Self-running test source: sends "AT\r\n" as UART frames, then idles GAP_CYCLES, forever.
// Define BT_TEST_PARITY_EN to add an even-parity bit to every frame.
module bt_test_tx
  import bt_test_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 5208,
  parameter int unsigned GAP_CYCLES   = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  output logic c
);

  localparam int unsigned      GAP_W   = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(MSG_LEN - 1);

  seq_e              seq_q, seq_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]  byte_idx_q, byte_idx_d;

  logic              start_c;
  logic [BYTE_W-1:0] data_c;
  logic              core_busy;
  logic              core_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= SEQ_GAP;
      gap_cnt_q  <= '0;
      byte_idx_q <= '0;
    end else begin
      seq_q      <= seq_d;
      gap_cnt_q  <= gap_cnt_d;
      byte_idx_q <= byte_idx_d;
    end
  end

  // Gap timing and message sequencing; the ROM is read only at a frame start
  always_comb begin
    seq_d      = seq_q;
    gap_cnt_d  = gap_cnt_q;
    byte_idx_d = byte_idx_q;
    start_c    = 1'b0;

    case (seq_q)
      SEQ_GAP: begin
        if (gap_cnt_q == GAP_MAX) begin
          if (!core_busy) begin
            start_c    = 1'b1;
            seq_d      = SEQ_SEND;
            gap_cnt_d  = '0;
            byte_idx_d = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      SEQ_SEND: begin
        if (core_done) begin
          byte_idx_d = byte_idx_q + IDX_W'(1);
          if (byte_idx_q == IDX_LAST) begin
            seq_d     = SEQ_GAP;
            gap_cnt_d = '0;
          end else begin
            start_c = 1'b1;
          end
        end
      end
      default: begin
        seq_d      = SEQ_GAP;
        gap_cnt_d  = '0;
        byte_idx_d = '0;
      end
    endcase

    data_c = msg_byte(byte_idx_d);
  end

  uart_tx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk    (clk),
    .rst    (rst),
    .start_i(start_c),
    .data_i (data_c),
    .c_o    (c),
    .busy_o (core_busy),
    .done_o (core_done)
  );

endmodule

// File: tb/tb_bt_test_tx.sv
// Bench for bt_test_tx: decodes UART frames on c and checks them against a byte scoreboard.
module tb_bt_test_tx;

  localparam int CPB = 4;
  localparam int GAP = 10;
`ifdef BT_TEST_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int PERIOD = GAP + 4 * FRAME_BITS * CPB;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic c;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_first  = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bt_test_tx #(
    .CLKS_PER_BIT(CPB),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .c  (c)
  );

  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
`ifdef BT_TEST_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  // Counts idle (c=1) cycles starting with the current one until a start bit appears
  task automatic wait_start(output int idle, output bit ok);
    idle = 0;
    ok   = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (c === 1'b0) begin
        ok = 1'b1;
        break;
      end
      idle++;
      @(negedge clk);
    end
  endtask

  // Called in the first start-bit cycle; returns with the bench in the first cycle after the frame
  task automatic read_frame(output logic [FRAME_BITS-1:0] bits);
    for (int b = 0; b < FRAME_BITS; b++) begin
      repeat ((b == 0) ? CPB / 2 : CPB) @(negedge clk);
      bits[b] = c;
    end
    repeat (CPB - CPB / 2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (c !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_c[%0d]: got %b want 1", i, c);
      end
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h54);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic test_message();
    int idle;
    bit ok;
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] expf;
    for (int i = 0; i < 4; i++) begin
      wait_start(idle, ok);
      n_checks++;
      if (!ok || idle != ((i == 0) ? GAP : 0)) begin
        n_fail++;
        $display("FAIL msg_idle[%0d]: got %0d (found=%0b) want %0d", i, idle, ok,
                 (i == 0) ? GAP : 0);
      end
      if (!ok) return;
      if (i == 0) t_first = cyc;
      read_frame(bits);
      expf = (exp_q.size() > 0) ? make_frame(exp_q.pop_front()) : '0;
      n_checks++;
      if (bits !== expf) begin
        n_fail++;
        $display("FAIL msg_frame[%0d]: got %b want %b", i, bits, expf);
      end
    end
  endtask

  task automatic test_gap_repeat();
    int idle;
    bit ok;
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] expf;
    exp_q.push_back(8'h41);
    wait_start(idle, ok);
    n_checks++;
    if (!ok || idle != GAP) begin
      n_fail++;
      $display("FAIL repeat_idle: got %0d (found=%0b) want %0d", idle, ok, GAP);
    end
    if (!ok) return;
    n_checks++;
    if (cyc - t_first != PERIOD) begin
      n_fail++;
      $display("FAIL repeat_period: got %0d want %0d", cyc - t_first, PERIOD);
    end
    read_frame(bits);
    expf = make_frame(exp_q.pop_front());
    n_checks++;
    if (bits !== expf) begin
      n_fail++;
      $display("FAIL repeat_frame: got %b want %b", bits, expf);
    end
  endtask

  // Entered in the first cycle of the 0x54 frame; reset lands inside its data bits
  task automatic test_rst_mid();
    int idle;
    bit ok;
    logic [FRAME_BITS-1:0] bits;
    logic [FRAME_BITS-1:0] expf;
    expf = make_frame(8'h54);
    repeat (4 * CPB + CPB / 2) @(negedge clk);
    n_checks++;
    if (c !== expf[4]) begin
      n_fail++;
      $display("FAIL rst_pre_c: got %b want %b", c, expf[4]);
    end
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (c !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_c: got %b want 1", c);
    end
    rst = 1'b0;
    exp_q.delete();
    exp_q.push_back(8'h41);
    wait_start(idle, ok);
    n_checks++;
    if (!ok || idle != GAP) begin
      n_fail++;
      $display("FAIL rst_idle: got %0d (found=%0b) want %0d", idle, ok, GAP);
    end
    if (!ok) return;
    read_frame(bits);
    expf = make_frame(exp_q.pop_front());
    n_checks++;
    if (bits !== expf) begin
      n_fail++;
      $display("FAIL rst_frame: got %b want %b", bits, expf);
    end
  endtask

  initial begin
    test_reset();
    test_message();
    test_gap_repeat();
    test_rst_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
